// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, FSM
// state encoding, per-opcode final execute step and the control bundle.
package cpu_ctrl_pkg;

  // Opcode field ir[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Sequencer state
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Fetch occupies T0..T2; execute always starts at T3
  localparam logic [2:0] STEP_FETCH_LAST = 3'd2;
  localparam logic [2:0] STEP_EXEC_FIRST = 3'd3;

  // Final execute step per opcode class
  localparam logic [2:0] LAST_SINGLE = 3'd3;  // jr, in, out, mfhi, mflo, nop, undefined
  localparam logic [2:0] LAST_NEGNOT = 3'd4;
  localparam logic [2:0] LAST_JAL    = 3'd4;
  localparam logic [2:0] LAST_ALU    = 3'd5;  // reg ALU, immediates, ldi
  localparam logic [2:0] LAST_MULDIV = 3'd6;
  localparam logic [2:0] LAST_BR     = 3'd6;
  localparam logic [2:0] LAST_LDST   = 3'd7;

  // Full set of strobes driven into the datapath
  typedef struct packed {
    logic       run;
    logic       pc_out;
    logic       mdr_out;
    logic       zlow_out;
    logic       zhigh_out;
    logic       hi_out;
    logic       lo_out;
    logic       c_out;
    logic       inport_out;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic       pc_en;
    logic       inc_pc;
    logic       mar_en;
    logic       mdr_en;
    logic       ir_en;
    logic       y_en;
    logic       zl_en;
    logic       zh_en;
    logic       hi_en;
    logic       lo_en;
    logic       outp_en;
    logic       con_in;
    logic       rd;
    logic       wr;
    logic [4:0] operation;
  } ctrl_t;

  // Last execute step for an opcode; undefined opcodes behave like nop
  function automatic logic [2:0] last_step(input logic [4:0] op);
    logic [2:0] r;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  r = LAST_ALU;
      OP_MUL, OP_DIV:                    r = LAST_MULDIV;
      OP_NEG, OP_NOT:                    r = LAST_NEGNOT;
      OP_JAL:                            r = LAST_JAL;
      OP_BR:                             r = LAST_BR;
      OP_LD, OP_ST:                      r = LAST_LDST;
      default:                           r = LAST_SINGLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// Combinational Moore decode: (state, step, opcode, con_ff) -> control bundle.
module ctrl_step_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_step,
  input  logic [4:0] i_opcode,
  input  logic       i_con_ff,
  output ctrl_t      o_ctrl
);

  // Strobe decode for the current step; everything idles unless named here
  always_comb begin
    // NOTE: the whole bundle gets a default first so no path leaves a field unassigned (no latches).
    o_ctrl           = '0;
    o_ctrl.operation = OP_ADD;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.run = 1'b1;
        case (i_step)
          3'd0: begin
            o_ctrl.pc_out = 1'b1; o_ctrl.mar_en = 1'b1;
            o_ctrl.inc_pc = 1'b1; o_ctrl.pc_en  = 1'b1;
          end
          3'd1: begin
            o_ctrl.rd = 1'b1; o_ctrl.mdr_en = 1'b1;
          end
          3'd2: begin
            o_ctrl.mdr_out = 1'b1; o_ctrl.ir_en = 1'b1;
          end
          default: ;
        endcase
      end

      ST_EXEC: begin
        o_ctrl.run = (i_opcode != OP_HALT);
        case (i_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            case (i_step)
              3'd3: begin o_ctrl.grb = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.y_en = 1'b1; end
              3'd4: begin
                o_ctrl.grc = 1'b1; o_ctrl.rout = 1'b1;
                o_ctrl.operation = i_opcode; o_ctrl.zl_en = 1'b1;
              end
              3'd5: begin o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1; end
              default: ;
            endcase
          end

          OP_MUL, OP_DIV: begin
            case (i_step)
              3'd3: begin o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.y_en = 1'b1; end
              3'd4: begin
                o_ctrl.grb = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.operation = i_opcode;
                o_ctrl.zl_en = 1'b1; o_ctrl.zh_en = 1'b1;
              end
              3'd5: begin o_ctrl.zlow_out = 1'b1; o_ctrl.lo_en = 1'b1; end
              3'd6: begin o_ctrl.zhigh_out = 1'b1; o_ctrl.hi_en = 1'b1; end
              default: ;
            endcase
          end

          OP_NEG, OP_NOT: begin
            case (i_step)
              3'd3: begin
                o_ctrl.grb = 1'b1; o_ctrl.rout = 1'b1;
                o_ctrl.operation = i_opcode; o_ctrl.zl_en = 1'b1;
              end
              3'd4: begin o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1; end
              default: ;
            endcase
          end

          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (i_step)
              3'd3: begin o_ctrl.grb = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.y_en = 1'b1; end
              3'd4: begin o_ctrl.c_out = 1'b1; o_ctrl.operation = i_opcode; o_ctrl.zl_en = 1'b1; end
              3'd5: begin o_ctrl.zlow_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1; end
              default: ;
            endcase
          end

          // ldi/ld/st share the Rb(or 0)+C effective-address computation in T3..T4
          OP_LDI, OP_LD, OP_ST: begin
            case (i_step)
              3'd3: begin o_ctrl.grb = 1'b1; o_ctrl.ba_out = 1'b1; o_ctrl.y_en = 1'b1; end
              3'd4: begin o_ctrl.c_out = 1'b1; o_ctrl.zl_en = 1'b1; end
              3'd5: begin
                o_ctrl.zlow_out = 1'b1;
                if (i_opcode == OP_LDI) begin
                  o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
                end else begin
                  o_ctrl.mar_en = 1'b1;
                end
              end
              3'd6: begin
                o_ctrl.mdr_en = 1'b1;
                if (i_opcode == OP_LD) begin
                  o_ctrl.rd = 1'b1;
                end else begin
                  o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1;
                end
              end
              3'd7: begin
                if (i_opcode == OP_LD) begin
                  o_ctrl.mdr_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
                end else begin
                  o_ctrl.wr = 1'b1;
                end
              end
              default: ;
            endcase
          end

          OP_BR: begin
            case (i_step)
              3'd3: begin o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.con_in = 1'b1; end
              3'd4: begin o_ctrl.pc_out = 1'b1; o_ctrl.y_en = 1'b1; end
              3'd5: begin o_ctrl.c_out = 1'b1; o_ctrl.zl_en = 1'b1; end
              3'd6: begin
                o_ctrl.zlow_out = i_con_ff;
                o_ctrl.pc_en    = i_con_ff;
              end
              default: ;
            endcase
          end

          OP_JR: begin
            if (i_step == 3'd3) begin
              o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.pc_en = 1'b1;
            end
          end

          OP_JAL: begin
            case (i_step)
              3'd3: begin o_ctrl.pc_out = 1'b1; o_ctrl.grb = 1'b1; o_ctrl.rin = 1'b1; end
              3'd4: begin o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.pc_en = 1'b1; end
              default: ;
            endcase
          end

          OP_IN: begin
            if (i_step == 3'd3) begin
              o_ctrl.inport_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
            end
          end

          OP_OUT: begin
            if (i_step == 3'd3) begin
              o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.outp_en = 1'b1;
            end
          end

          OP_MFHI: begin
            if (i_step == 3'd3) begin
              o_ctrl.hi_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
            end
          end

          OP_MFLO: begin
            if (i_step == 3'd3) begin
              o_ctrl.lo_out = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
            end
          end

          // nop, halt and undefined opcodes drive no strobes
          default: ;
        endcase
      end

      // RESET and HALT: everything idle, run low
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC multi-cycle control sequencer: holds the state/step registers and
// walks fetch (T0..T2) then the per-opcode execute steps (T3..T7).
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        run,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_low_enable,
  output logic        Z_high_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        Output_port_enable,
  output logic        CON_in,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation
);

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  state_t              w_state_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic [4:0]          w_opcode;
  logic                w_last;
  ctrl_t               w_ctrl;
  logic                w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_unused_ir = ^ir[26:0];
  assign w_last      = (r_step >= STEP_W'(last_step(w_opcode)));

  // State/step register; clear drops straight to RESET so strobes die immediately
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_RESET;
      r_step  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Next state/step: fetch T0..T2, execute T3..last, then back to T0
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    case (r_state)
      ST_RESET: begin
        w_state_nxt = ST_FETCH;
        w_step_nxt  = '0;
      end
      ST_FETCH: begin
        if (r_step == STEP_W'(STEP_FETCH_LAST)) begin
          w_state_nxt = ST_EXEC;
          w_step_nxt  = STEP_W'(STEP_EXEC_FIRST);
        end else begin
          w_step_nxt  = r_step + STEP_W'(1);
        end
      end
      ST_EXEC: begin
        if (w_opcode == OP_HALT) begin
          w_state_nxt = ST_HALT;
          w_step_nxt  = '0;
        end else if (w_last) begin
          w_state_nxt = ST_FETCH;
          w_step_nxt  = '0;
        end else begin
          w_step_nxt  = r_step + STEP_W'(1);
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
        w_step_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_step_nxt  = '0;
      end
    endcase
  end

  ctrl_step_decode u_decode (
    .i_state  (r_state),
    .i_step   (3'(r_step)),
    .i_opcode (w_opcode),
    .i_con_ff (con_ff),
    .o_ctrl   (w_ctrl)
  );

  assign run                = w_ctrl.run;
  assign PCout              = w_ctrl.pc_out;
  assign MDRout             = w_ctrl.mdr_out;
  assign ZLowout            = w_ctrl.zlow_out;
  assign ZHighout           = w_ctrl.zhigh_out;
  assign HIout              = w_ctrl.hi_out;
  assign LOout              = w_ctrl.lo_out;
  assign Cout               = w_ctrl.c_out;
  assign InPortout          = w_ctrl.inport_out;
  assign GRA                = w_ctrl.gra;
  assign GRB                = w_ctrl.grb;
  assign GRC                = w_ctrl.grc;
  assign Rin                = w_ctrl.rin;
  assign Rout               = w_ctrl.rout;
  assign BAout              = w_ctrl.ba_out;
  assign PC_enable          = w_ctrl.pc_en;
  assign IncPC              = w_ctrl.inc_pc;
  assign MAR_enable         = w_ctrl.mar_en;
  assign MDR_enable         = w_ctrl.mdr_en;
  assign IR_enable          = w_ctrl.ir_en;
  assign Y_enable           = w_ctrl.y_en;
  assign Z_low_enable       = w_ctrl.zl_en;
  assign Z_high_enable      = w_ctrl.zh_en;
  assign HI_enable          = w_ctrl.hi_en;
  assign LO_enable          = w_ctrl.lo_en;
  assign Output_port_enable = w_ctrl.outp_en;
  assign CON_in             = w_ctrl.con_in;
  assign Read               = w_ctrl.rd;
  assign Write              = w_ctrl.wr;
  assign operation          = w_ctrl.operation;

endmodule
